// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_if : CPU / DMA requester and memory-side bus bundle       |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
interface mem_arbiter_if #(
    parameter int WORD_BITS = 16
);
    logic                 cpu_req;
    logic                 cpu_we;
    logic [WORD_BITS-1:0] cpu_addr;
    logic [WORD_BITS-1:0] cpu_wdata;
    logic [WORD_BITS-1:0] cpu_rdata;
    logic                 cpu_ack;

    logic                 dma_req;
    logic                 dma_we;
    logic [WORD_BITS-1:0] dma_addr;
    logic [WORD_BITS-1:0] dma_wdata;
    logic [WORD_BITS-1:0] dma_rdata;
    logic                 dma_ack;

    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_BITS-1:0] mem_addr;
    logic [WORD_BITS-1:0] mem_wdata;
    logic [WORD_BITS-1:0] mem_rdata;
    logic                 mem_ready;

    logic                 owner;
    logic                 timeout_err;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output owner, timeout_err
    );

    // Requester / memory view
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  owner, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : two-requester (CPU/DMA) single-port memory arbiter      |
// |   with wait-state timeout. Define MEM_ARBITER_ROUND_ROBIN_EN for      |
// |   round-robin tie-break (default: CPU fixed priority).               |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module mem_arbiter #(
    parameter int WORD_BITS = 16,
    parameter int TIMEOUT   = 15
) (
    input wire           clk,
    input wire           reset_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        c_IDLE   = 2'd0,
        c_ACCESS = 2'd1,
        c_RESP   = 2'd2
    } state_t;

    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_we;
    logic [WORD_BITS-1:0] r_addr;
    logic [WORD_BITS-1:0] r_wdata;
    logic [WORD_BITS-1:0] r_rdata;
    logic                 r_owner;
    logic [7:0]           r_wait;
    logic                 r_tmo;

    logic w_any_req;
    logic w_grant_dma;
    logic w_expired;
    logic w_mem_read;
    logic w_mem_write;
    logic w_cpu_ack;
    logic w_dma_ack;
    logic w_tmo_err;

    assign w_any_req = bus.cpu_req | bus.dma_req;
    assign w_expired = (r_wait == c_WAIT_LAST);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // On a tie, the requester that did not own the bus last time wins
    assign w_grant_dma = bus.dma_req & (~bus.cpu_req | ~r_owner);
`else
    assign w_grant_dma = bus.dma_req & ~bus.cpu_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_cpu_ack    = 1'b0;
        w_dma_ack    = 1'b0;
        w_tmo_err    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_any_req) w_next_state = c_ACCESS;
            end
            c_ACCESS: begin
                w_mem_read  = ~r_we;
                w_mem_write = r_we;
                if (bus.mem_ready || w_expired) w_next_state = c_RESP;
            end
            c_RESP: begin
                w_cpu_ack    = ~r_owner;
                w_dma_ack    = r_owner;
                w_tmo_err    = r_tmo;
                w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_owner <= 1'b1;
            r_wait  <= '0;
            r_tmo   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_dma;
                        r_we    <= w_grant_dma ? bus.dma_we    : bus.cpu_we;
                        r_addr  <= w_grant_dma ? bus.dma_addr  : bus.cpu_addr;
                        r_wdata <= w_grant_dma ? bus.dma_wdata : bus.cpu_wdata;
                        r_wait  <= '0;
                        r_tmo   <= 1'b0;
                    end
                end
                c_ACCESS: begin
                    if (bus.mem_ready) begin
                        if (!r_we) r_rdata <= bus.mem_rdata;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                        if (w_expired) begin
                            r_rdata <= '1;
                            r_tmo   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_read    = w_mem_read;
    assign bus.mem_write   = w_mem_write;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wdata   = r_wdata;
    assign bus.cpu_ack     = w_cpu_ack;
    assign bus.dma_ack     = w_dma_ack;
    assign bus.cpu_rdata   = r_rdata;
    assign bus.dma_rdata   = r_rdata;
    assign bus.owner       = r_owner;
    assign bus.timeout_err = w_tmo_err;
endmodule
`default_nettype wire
